// File: rtl/dma_sched_pkg.sv
// Shared types and constants for the streaming DMA burst scheduler.
package dma_sched_pkg;

   localparam int DMA_DEF_BURST_DW = 32;
   localparam int DMA_ADDR_W       = 30;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_DATA = 3'd1,
      ST_START     = 3'd2,
      ST_XFER      = 3'd3,
      ST_UPDATE    = 3'd4
   } dma_state_e;

endpackage

// File: rtl/dma_stream_sched.sv
// Schedules fixed-size DMA write bursts from the acquisition FIFO into a host ring buffer.
// Optional macro DMA_SCHED_INT_EN builds the half/full-buffer interrupt pulse on start_int_o.
module dma_stream_sched
   import dma_sched_pkg::*;
#(
   parameter int BURST_DW = DMA_DEF_BURST_DW,
   parameter int OFS_W    = 20
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  bus_mstr_en,
   input  logic [DMA_ADDR_W-1:0] host_base,
   input  logic [OFS_W-1:0]      buf_size_dw,
   input  logic [11:0]           fifo_level,
   input  logic                  fifo_full,
   input  logic                  dma_rd_en,
   output logic                  dma_start,
   output logic [DMA_ADDR_W-1:0] dma_addr,
   output logic                  start_int_o,
   output logic [OFS_W-1:0]      wr_offset,
   output logic                  overflow,
   output logic                  busy
);

   localparam int BEAT_W = $clog2(BURST_DW) + 1;

   dma_state_e            state_q, state_d;
   logic                  enable_q;
   logic [DMA_ADDR_W-1:0] base_q, base_d;
   logic [OFS_W-1:0]      size_q, size_d;
   logic [OFS_W-1:0]      offset_q, offset_d;
   logic [BEAT_W-1:0]     beat_q, beat_d;
   logic [DMA_ADDR_W-1:0] addr_q, addr_d;
   logic                  ovf_q, ovf_d;

   logic [OFS_W-1:0]      next_raw;
   logic                  wrap;
   logic                  enable_rise;

   assign enable_rise = enable & ~enable_q;
   assign next_raw    = offset_q + OFS_W'(BURST_DW);
   assign wrap        = (next_raw == size_q);

   // NOTE: every variable gets its default before the case so no path infers a latch.
   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      size_d   = size_q;
      offset_d = offset_q;
      beat_d   = beat_q;
      addr_d   = addr_q;
      ovf_d    = ovf_q | (fifo_full & enable);

      unique case (state_q)
         ST_IDLE: begin
            if (enable_rise) begin
               base_d   = host_base;
               size_d   = buf_size_dw;
               offset_d = '0;
               ovf_d    = 1'b0;
               state_d  = ST_WAIT_DATA;
            end
         end
         ST_WAIT_DATA: begin
            if (!enable) begin
               state_d = ST_IDLE;
            end else if (fifo_level >= 12'(BURST_DW) && bus_mstr_en) begin
               addr_d  = base_q + DMA_ADDR_W'(offset_q);
               state_d = ST_START;
            end
         end
         ST_START: begin
            beat_d  = '0;
            state_d = ST_XFER;
         end
         ST_XFER: begin
            // Burst always runs to completion, even if enable drops mid-TLP.
            if (dma_rd_en) begin
               beat_d = beat_q + BEAT_W'(1);
               if (beat_q + BEAT_W'(1) == BEAT_W'(BURST_DW)) begin
                  state_d = ST_UPDATE;
               end
            end
         end
         ST_UPDATE: begin
            offset_d = wrap ? '0 : next_raw;
            state_d  = enable ? ST_WAIT_DATA : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         enable_q <= 1'b0;
         base_q   <= '0;
         size_q   <= '0;
         offset_q <= '0;
         beat_q   <= '0;
         addr_q   <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         enable_q <= enable;
         base_q   <= base_d;
         size_q   <= size_d;
         offset_q <= offset_d;
         beat_q   <= beat_d;
         addr_q   <= addr_d;
         ovf_q    <= ovf_d;
      end
   end

`ifdef DMA_SCHED_INT_EN
   logic int_q, int_d;

   assign int_d = (state_q == ST_UPDATE) && (wrap || next_raw == (size_q >> 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         int_q <= 1'b0;
      end else begin
         int_q <= int_d;
      end
   end

   assign start_int_o = int_q;
`else
   assign start_int_o = 1'b0;
`endif

   assign dma_start = (state_q == ST_START);
   assign dma_addr  = addr_q;
   assign wr_offset = offset_q;
   assign overflow  = ovf_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dma_stream_sched.sv
// Directed self-checking bench for dma_stream_sched (BURST_DW=32, OFS_W=20).
module tb_dma_stream_sched;

`ifdef DMA_SCHED_INT_EN
   localparam bit INT_EN = 1'b1;
`else
   localparam bit INT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        enable = 1'b0;
   logic        bus_mstr_en = 1'b0;
   logic [29:0] host_base = '0;
   logic [19:0] buf_size_dw = '0;
   logic [11:0] fifo_level = '0;
   logic        fifo_full = 1'b0;
   logic        dma_rd_en = 1'b0;
   logic        dma_start;
   logic [29:0] dma_addr;
   logic        start_int_o;
   logic [19:0] wr_offset;
   logic        overflow;
   logic        busy;

   int errors = 0;
   int checks = 0;

   dma_stream_sched #(.BURST_DW(32), .OFS_W(20)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .bus_mstr_en (bus_mstr_en),
      .host_base   (host_base),
      .buf_size_dw (buf_size_dw),
      .fifo_level  (fifo_level),
      .fifo_full   (fifo_full),
      .dma_rd_en   (dma_rd_en),
      .dma_start   (dma_start),
      .dma_addr    (dma_addr),
      .start_int_o (start_int_o),
      .wr_offset   (wr_offset),
      .overflow    (overflow),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_outputs_zero(input string tag);
      checks++;
      if ({dma_start, dma_addr, start_int_o, wr_offset, overflow, busy} !== '0) begin
         errors++;
         $display("FAIL %s outputs: start=%b addr=%h int=%b ofs=%h ovf=%b busy=%b, required all 0",
                  tag, dma_start, dma_addr, start_int_o, wr_offset, overflow, busy);
      end
   endtask

   // Waits for dma_start, checks address, plays 32 endpoint beats, checks offset/interrupt.
   task automatic run_burst(input string tag, input logic [29:0] exp_addr,
                            input logic [19:0] exp_ofs, input logic exp_int);
      int n = 0;
      while (dma_start !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      checks++;
      if (dma_start !== 1'b1) begin
         errors++;
         $display("FAIL %s start_timeout: dma_start=%b after %0d cycles, required 1", tag, dma_start, n);
         return;
      end
      checks++;
      if (dma_addr !== exp_addr) begin
         errors++;
         $display("FAIL %s addr: got %h, required %h", tag, dma_addr, exp_addr);
      end
      tick();
      checks++;
      if (dma_start !== 1'b0) begin
         errors++;
         $display("FAIL %s start_width: dma_start=%b in XFER, required 0", tag, dma_start);
      end
      dma_rd_en = 1'b1;
      for (int i = 0; i < 32; i++) tick();
      dma_rd_en = 1'b0;
      checks++;
      if (dma_addr !== exp_addr || busy !== 1'b1) begin
         errors++;
         $display("FAIL %s addr_hold: addr=%h busy=%b, required %h busy=1", tag, dma_addr, busy, exp_addr);
      end
      tick();
      checks++;
      if (wr_offset !== exp_ofs) begin
         errors++;
         $display("FAIL %s offset: got %h, required %h", tag, wr_offset, exp_ofs);
      end
      checks++;
      if (start_int_o !== (exp_int & INT_EN)) begin
         errors++;
         $display("FAIL %s int: got %b, required %b", tag, start_int_o, exp_int & INT_EN);
      end
   endtask

   task automatic go_idle();
      fifo_level = '0;
      enable     = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      repeat (3) tick();
      check_outputs_zero("reset");
      rst_n = 1'b1;
      tick();
      check_outputs_zero("post_reset");
   endtask

   task automatic test_streaming();
      host_base   = 30'h0400_0000;
      buf_size_dw = 20'd128;
      fifo_level  = 12'd64;
      bus_mstr_en = 1'b1;
      enable      = 1'b1;
      tick();
      run_burst("stream_b1", 30'h0400_0000, 20'd32, 1'b0);
      run_burst("stream_b2", 30'h0400_0020, 20'd64, 1'b1);
      run_burst("stream_b3", 30'h0400_0040, 20'd96, 1'b0);
      run_burst("stream_b4", 30'h0400_0060, 20'd0,  1'b1);
      run_burst("stream_b5", 30'h0400_0000, 20'd32, 1'b0);
      go_idle();
   endtask

   task automatic test_threshold();
      int starts = 0;
      host_base   = 30'h0000_0100;
      buf_size_dw = 20'd64;
      fifo_level  = 12'd31;
      enable      = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) begin
         tick();
         if (dma_start === 1'b1) starts++;
      end
      checks++;
      if (starts != 0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL level31: starts=%0d busy=%b, required 0 starts busy=1", starts, busy);
      end
      fifo_level = 12'd32;
      tick();
      checks++;
      if (dma_start !== 1'b1) begin
         errors++;
         $display("FAIL level32_latency: dma_start=%b one cycle after level 32, required 1", dma_start);
      end
      run_burst("level32", 30'h0000_0100, 20'd32, 1'b1);
      go_idle();
   endtask

   task automatic test_enable_drop();
      int starts = 0;
      host_base   = 30'h0000_0200;
      buf_size_dw = 20'd128;
      fifo_level  = 12'd64;
      enable      = 1'b1;
      tick();
      tick();
      checks++;
      if (dma_start !== 1'b1 || dma_addr !== 30'h0000_0200) begin
         errors++;
         $display("FAIL drop_start: start=%b addr=%h, required 1 and 00000200", dma_start, dma_addr);
      end
      tick();
      dma_rd_en = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      enable = 1'b0;
      for (int i = 0; i < 21; i++) tick();
      checks++;
      if (busy !== 1'b1 || wr_offset !== 20'd0) begin
         errors++;
         $display("FAIL drop_beat31: busy=%b ofs=%h, required busy=1 ofs=0", busy, wr_offset);
      end
      tick();
      dma_rd_en = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0 || wr_offset !== 20'd32) begin
         errors++;
         $display("FAIL drop_end: busy=%b ofs=%h, required busy=0 ofs=20", busy, wr_offset);
      end
      for (int i = 0; i < 40; i++) begin
         tick();
         if (dma_start === 1'b1) starts++;
      end
      checks++;
      if (starts != 0) begin
         errors++;
         $display("FAIL drop_no_restart: starts=%0d, required 0", starts);
      end
      go_idle();
   endtask

   task automatic test_bus_master();
      int starts = 0;
      host_base   = 30'h0000_0300;
      buf_size_dw = 20'd128;
      fifo_level  = 12'd64;
      bus_mstr_en = 1'b0;
      enable      = 1'b1;
      tick();
      for (int i = 0; i < 10; i++) begin
         tick();
         if (dma_start === 1'b1) starts++;
      end
      checks++;
      if (starts != 0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL mstr_low: starts=%0d busy=%b, required 0 starts busy=1", starts, busy);
      end
      bus_mstr_en = 1'b1;
      tick();
      checks++;
      if (dma_start !== 1'b1) begin
         errors++;
         $display("FAIL mstr_high: dma_start=%b, required 1", dma_start);
      end
      run_burst("mstr", 30'h0000_0300, 20'd32, 1'b0);
      go_idle();
   endtask

   task automatic test_overflow();
      host_base   = 30'h0000_0400;
      buf_size_dw = 20'd128;
      fifo_level  = 12'd64;
      enable      = 1'b1;
      tick();
      run_burst("ovf_pre", 30'h0000_0400, 20'd32, 1'b0);
      fifo_level = '0;
      fifo_full  = 1'b1;
      tick();
      fifo_full  = 1'b0;
      repeat (5) tick();
      checks++;
      if (overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_sticky: overflow=%b, required 1", overflow);
      end
      enable = 1'b0;
      tick();
      checks++;
      if (overflow !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL ovf_idle: overflow=%b busy=%b, required 1 and 0", overflow, busy);
      end
      enable = 1'b1;
      tick();
      checks++;
      if (overflow !== 1'b0 || wr_offset !== 20'd0) begin
         errors++;
         $display("FAIL ovf_clear: overflow=%b ofs=%h, required 0 and 0", overflow, wr_offset);
      end
      enable = 1'b0;
      tick();
      fifo_full = 1'b1;
      tick();
      fifo_full = 1'b0;
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL ovf_disabled: overflow=%b, required 0", overflow);
      end
   endtask

   task automatic test_reset_mid();
      host_base   = 30'h0000_0500;
      buf_size_dw = 20'd128;
      fifo_level  = 12'd64;
      enable      = 1'b1;
      tick();
      run_burst("rst_pre", 30'h0000_0500, 20'd32, 1'b0);
      tick();
      dma_rd_en = 1'b1;
      repeat (5) tick();
      #2 rst_n = 1'b0;
      #1;
      check_outputs_zero("reset_mid");
      dma_rd_en = 1'b0;
      enable    = 1'b0;
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      check_outputs_zero("reset_release");
      host_base = 30'h0000_0600;
      enable    = 1'b1;
      tick();
      run_burst("rst_restart", 30'h0000_0600, 20'd32, 1'b0);
      go_idle();
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_threshold();
      test_enable_drop();
      test_bus_master();
      test_overflow();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
